// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter guarding one shared W-bit register.
// A winner is picked in IDLE, its command is applied in GRANT, and ACK
// finishes the handshake and advances the round-robin pointer.
// Optional feature: define ARB_LOCK_EN to add a per-requester lock input
// that keeps the pointer on the winner so it can win repeatedly.
module shared_reg_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic [W*NREQ-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic              done,
    output logic              busy,
    output logic [W-1:0]      q
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IW + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        ACK   = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;
    logic [W-1:0]    q_q, q_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    data_q, data_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW1-1:0]  cand_w;
    logic [IW-1:0]   cand_idx;
    logic [1:0]      sel_op;
    logic [W-1:0]    sel_data;
    logic [IW-1:0]   ptr_next;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_w    = '0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, ptr_q} + IW1'(k);
            if (cand_w >= IW1'(NREQ)) begin
                cand_w = cand_w - IW1'(NREQ);
            end
            cand_idx = cand_w[IW-1:0];
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Pick out the winner's command and load data slices.
    always_comb begin
        sel_op   = 2'b11;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_op   = op[2*i +: 2];
                sel_data = wdata[W*i +: W];
            end
        end
    end

    // Pointer value after a completed grant: winner + 1, or held under lock.
    always_comb begin
        if (win_q == IW'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_q + IW'(1);
        end
`ifdef ARB_LOCK_EN
        if (lock[win_q]) begin
            ptr_next = win_q;
        end
`endif
    end

    // Next-state logic: sample in IDLE, apply in GRANT, release in ACK.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 1'b0;
        q_d     = q_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    win_d          = win_idx;
                    op_d           = sel_op;
                    data_d         = sel_data;
                    gnt_d[win_idx] = 1'b1;
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                case (op_q)
                    OP_LOAD:  q_d = data_q;
                    OP_SET:   q_d = '1;
                    OP_CLEAR: q_d = '0;
                    default:  q_d = q_q;
                endcase
                done_d  = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                gnt_d   = '0;
                done_d  = 1'b0;
                ptr_d   = ptr_next;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            q_q     <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            q_q     <= q_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign q    = q_q;
    assign busy = (state_q != IDLE);

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (2..8).
REQ-002 Parameter: W, 8, width of the shared register.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  NREQ  per-requester access request, level.
REQ-006 Port: op  input  2*NREQ  per-requester command, slice [2i+1:2i]; encodings 00 = load, 01 = set all ones, 10 = clear to zero, 11 = hold.
REQ-007 Port: wdata  input  W*NREQ  per-requester load data, slice [W*i+W-1:W*i].
REQ-008 Port: gnt  output  NREQ  one-hot grant; zero when idle.
REQ-009 Port: done  output  1  one-cycle completion pulse for the granted requester.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: q  output  W  shared register contents.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and ACK.
REQ-013 IDLE SHALL transition on a clock edge where any req bit is high:
- latch the winner's op and wdata;
- set gnt to the winner's one-hot code;
- go to GRANT.
Otherwise IDLE SHALL remain in IDLE with gnt = 0.
REQ-014 GRANT SHALL transition on the next edge:
- update q from the latched op (load: q = latched wdata; set: all ones; clear: zero; hold: unchanged);
- drive done = 1;
- go to ACK.
REQ-015 ACK SHALL transition on the next edge:
- drive done = 0 and gnt = 0;
- set the round-robin pointer to the winner index + 1, modulo NREQ;
- go to IDLE.
REQ-016 Latency:
- req sampled high in IDLE gives gnt visible 1 cycle later;
- q is updated and done is high 2 cycles later;
- the next arbitration can happen no earlier than 3 cycles after the request.
REQ-017 Arbitration SHALL be round-robin. The search starts at the pointer index and increases with wrap-around; the first index with req high wins.
REQ-018 req, op and wdata SHALL be sampled only in IDLE. Changes during GRANT or ACK, including req withdrawal, SHALL NOT cancel or alter the latched operation.
REQ-019 A requester whose req is still high when the FSM returns to IDLE SHALL compete again normally. Under continuous contention, no requester waits more than NREQ-1 grants.
REQ-020 gnt SHALL be one-hot or zero in every cycle, and done SHALL never be high for two consecutive cycles.
REQ-021 q SHALL change only on the GRANT-to-ACK edge, or on reset.

Reset
REQ-022 On rst low, the block SHALL immediately and asynchronously force:
- state = IDLE;
- q = 0, gnt = 0, done = 0, busy = 0;
- round-robin pointer = 0;
- latched op and data discarded.
REQ-023 A reset asserted in GRANT or ACK SHALL abort the operation; the pending write SHALL NOT take effect.
REQ-024 After rst is released, the first rising edge SHALL perform a normal IDLE evaluation.

Configuration
REQ-025 Macro ARB_LOCK_EN, when defined, SHALL add the port lock  input  NREQ  per-requester lock request.
REQ-026 With ARB_LOCK_EN defined, if the winner's lock bit is high on the ACK-to-IDLE edge:
- the pointer SHALL stay at the winner index instead of advancing;
- that requester SHALL win the next IDLE arbitration whenever its req is high.
The lock SHALL be released when the winner's lock bit is low at ACK.
REQ-027 With ARB_LOCK_EN undefined, the lock port SHALL be absent and arbitration SHALL be pure round-robin per REQ-017.

Verification
REQ-028 Reset then idle: rst low, then high, with req = 0 for 10 cycles -> q = 0x00, gnt = 0, done = 0 and busy = 0 throughout.
REQ-029 Single load: req = 0001, op[1:0] = 00, wdata[7:0] = 0xA5 -> gnt = 0001 at cycle +1; q = 0xA5 and done = 1 at cycle +2; gnt = 0 at cycle +3.
REQ-030 Contention: req = 1111 held, all ops set/clear alternating -> grants in the order 0001, 0010, 0100, 1000, 0001, with exactly one done per grant.
REQ-031 Wrap and withdraw: pointer = 3 and req = 1001 -> gnt = 1000 first. Requester 3 drops req during GRANT -> the write still completes and done still pulses.
REQ-032 Reset mid-operation: rst low during GRANT with op = set -> q stays 0x00, and gnt and done return to 0 immediately.
REQ-033 Lock (ARB_LOCK_EN defined): req = 0011 and lock[0] = 1 -> requester 0 is granted three consecutive times. Dropping lock[0] -> the next grant goes to requester 1 (0010).
